id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand front-end for the execute stage. Latches decoded
//  instructions, detects load-use hazards and forwards MEM/WB results. Drives ALU operands
//  A/B and alu_ctrl (`ADD..`BUF codes), plus store data and control to EX/MEM.
//  One-cycle ID->EX latency.
// PARAMETERS
//  XLEN      32     datapath width
//  REG_AW    5      register-index width
//  RESET_PC  32'h0  ex_pc value on reset and on bubbles
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  id_valid       in   1      decode slot holds a real instruction
//  id_pc          in   XLEN   instruction PC
//  id_rs1/id_rs2  in   REG_AW source register indices
//  id_rs1_used    in   1      instruction reads rs1 (same for id_rs2_used)
//  id_rs2_used    in   1      instruction reads rs2
//  id_rs1_data    in   XLEN   regfile read data, rs1 (same for id_rs2_data)
//  id_rs2_data    in   XLEN   regfile read data, rs2
//  id_imm         in   XLEN   sign-extended immediate
//  id_rd          in   REG_AW destination register
//  id_alu_ctrl    in   4      ALU opcode, `parameters.vh` encoding
//  id_use_imm     in   1      B := imm instead of rs2
//  id_use_pc      in   1      A := pc instead of rs1 (AUIPC/JAL)
//  id_reg_write   in   1      control bit, carried to EX
//  id_mem_read    in   1      control bit, carried to EX
//  id_mem_write   in   1      control bit, carried to EX
//  mem_stall      in   1      downstream busy: hold EX register
//  flush          in   1      kill instruction entering EX (taken branch/jump)
//  mem_rd         in   REG_AW MEM-stage destination; mem_reg_write in 1; mem_result in XLEN
//  wb_rd          in   REG_AW WB-stage destination; wb_reg_write in 1; wb_result in XLEN
//  id_stall       out  1      freeze PC/IF/ID; combinational
//  ex_valid       out  1      EX holds a real instruction
//  ex_pc          out  XLEN   registered PC
//  ex_A/ex_B      out  XLEN   ALU operands after forwarding/select
//  ex_alu_ctrl    out  4      registered ALU opcode
//  ex_store_data  out  XLEN   forwarded rs2 value
//  ex_rd          out  REG_AW registered destination
//  ex_reg_write   out  1      registered control bit
//  ex_mem_read    out  1      registered control bit
//  ex_mem_write   out  1      registered control bit
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - ex_valid/reg_write/mem_read/mem_write=0, ex_rd=0, stored operands/imm=0
//    - ex_pc=RESET_PC, ex_alu_ctrl=`ADD
//  - Bubble = same values as reset; ex_rd=0, so a bubble never matches a hazard compare.
//  - Edge priority: flush > mem_stall (hold) > id_stall (load bubble) > capture id_*.
//  - flush and mem_stall are never asserted together; the branch unit guarantees this.
//    If both are high anyway, flush wins.
//  - hazard(r) = id_valid & used & r!=0 & r==ex_rd & ex_valid & ex_reg_write.
//  - Load-use: id_stall = hazard(rs1|rs2) & ex_mem_read. The next edge loads a bubble.
//  - id_stall is forced 0 while flush=1.
//  - id_stall is ORed with mem_stall, so decode also freezes during a hold.
//  - Forward mux, per source, combinational on the registered index:
//    1. MEM hit: mem_reg_write & mem_rd==idx & idx!=0
//    2. WB hit: wb_reg_write & wb_rd==idx & idx!=0
//    3. otherwise: stored regfile data
//  - x0 is never forwarded; MEM has priority over WB.
//  - During hold, if WB matches a stored source, the stored data is overwritten with
//    wb_result, so the value survives WB retirement.
//  - ex_A = use_pc ? ex_pc : fwd_rs1;  ex_B = use_imm ? imm : fwd_rs2;
//    ex_store_data = fwd_rs2.
//  - No arithmetic; widths pass straight through.
// CONFIGURATION
//  - OPERAND_FORWARD_EN defined: forwarding as above.
//  - Undefined: forward mux removed; ex_A/B use stored data only.
//  - Undefined: id_stall also asserts on any RAW match against EX, MEM or WB.
//  - Undefined: the hold-time WB capture is still kept.
// STRUCTURE
//  - ALU opcodes, register-index width and RESET_PC default live in parameters.vh.
//  - One sub-module: operand_fwd_mux (one instance per source; idx, stored data,
//    MEM/WB triple -> value). Hazard logic and register stay inline.
// TESTING
//  - Reset: hold rst_n=0 mid-instruction -> ex_valid=0, ex_alu_ctrl=`ADD, ex_A=ex_B=0
//    immediately, without a clock.
//  - Capture: id add x3,x1,x2 with rs1=5, rs2=7 -> next cycle ex_A=5, ex_B=7,
//    ex_rd=3, ex_alu_ctrl=`ADD.
//  - Forward priority: EX rs1=4; mem_rd=4 (0xAA), wb_rd=4 (0xBB) -> ex_A=0xAA.
//    Drop MEM -> ex_A=0xBB. With rs1=0 and mem_rd=0 -> ex_A=stored value.
//  - Load-use: EX lw x6; ID reads x6 -> id_stall=1 for one cycle.
//    Then a bubble (ex_valid=0), then the consumer enters with the MEM-forwarded value.
//  - Hold: mem_stall=1 for 3 cycles while WB writes matching rs2=0x55.
//    -> EX unchanged; after release ex_B=0x55.
//  - Flush vs load-use in the same cycle -> id_stall=0, next ex_valid=0.
//    Without OPERAND_FORWARD_EN, a back-to-back RAW stalls 3 cycles.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: default widths, reset PC and ALU opcode encoding shared by the ID/EX stage.
package id_ex_stage_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_BUF
  } alu_op_e;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: picks MEM result, then WB result, then stored data for one source register.
// With FWD_EN=0 the stored data always passes through.
module operand_fwd_mux #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  input  logic [XLEN-1:0]   mem_result_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [XLEN-1:0]   wb_result_i,
  output logic [XLEN-1:0]   val_o
);
  logic mem_hit, wb_hit;
  assign mem_hit = FWD_EN && mem_reg_write_i && idx_i != '0 && mem_rd_i == idx_i;
  assign wb_hit  = FWD_EN && wb_reg_write_i && idx_i != '0 && wb_rd_i == idx_i;
  assign val_o   = mem_hit ? mem_result_i : wb_hit ? wb_result_i : stored_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use detection and MEM/WB operand forwarding.
// OPERAND_FORWARD_EN enables forwarding; without it any RAW against EX/MEM/WB stalls decode.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_use_imm,
  input  logic              id_use_pc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_A,
  output logic [XLEN-1:0]   ex_B,
  output logic [3:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
`ifdef OPERAND_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  logic              valid_q, valid_d, use_imm_q, use_imm_d, use_pc_q, use_pc_d;
  logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
  logic [XLEN-1:0]   pc_q, pc_d, d1_q, d1_d, d2_q, d2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]        alu_q, alu_d;
  logic [XLEN-1:0]   fwd1, fwd2;
  logic              hz1, hz2, haz_stall, hold, bubble;
  function automatic logic hit(input logic [REG_AW-1:0] idx, input logic [REG_AW-1:0] rd,
                               input logic we);
    return we && idx != '0 && idx == rd;
  endfunction
  assign hz1 = id_valid && id_rs1_used && hit(id_rs1, rd_q, valid_q && rw_q);
  assign hz2 = id_valid && id_rs2_used && hit(id_rs2, rd_q, valid_q && rw_q);
`ifdef OPERAND_FORWARD_EN
  assign haz_stall = (hz1 || hz2) && mr_q;
`else
  assign haz_stall = hz1 || hz2 || (id_valid &&
    ((id_rs1_used && (hit(id_rs1, mem_rd, mem_reg_write) || hit(id_rs1, wb_rd, wb_reg_write))) ||
     (id_rs2_used && (hit(id_rs2, mem_rd, mem_reg_write) || hit(id_rs2, wb_rd, wb_reg_write)))));
`endif
  assign id_stall = !flush && (haz_stall || mem_stall);
  assign hold     = !flush && mem_stall;
  assign bubble   = flush || (!mem_stall && (haz_stall || !id_valid));
  // a held source grabs the WB result so it survives that instruction retiring
  always_comb begin
    valid_d = valid_q; pc_d = pc_q; rs1_d = rs1_q; rs2_d = rs2_q; imm_d = imm_q;
    rd_d = rd_q; alu_d = alu_q; use_imm_d = use_imm_q; use_pc_d = use_pc_q;
    rw_d = rw_q; mr_d = mr_q; mw_d = mw_q;
    d1_d = hold && hit(rs1_q, wb_rd, wb_reg_write) ? wb_result : d1_q;
    d2_d = hold && hit(rs2_q, wb_rd, wb_reg_write) ? wb_result : d2_q;
    if (bubble) begin
      valid_d = 1'b0; pc_d = RESET_PC; rs1_d = '0; rs2_d = '0; d1_d = '0; d2_d = '0;
      imm_d = '0; rd_d = '0; alu_d = ALU_ADD; use_imm_d = 1'b0; use_pc_d = 1'b0;
      rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0;
    end else if (!hold) begin
      valid_d = 1'b1; pc_d = id_pc; rs1_d = id_rs1; rs2_d = id_rs2; d1_d = id_rs1_data;
      d2_d = id_rs2_data; imm_d = id_imm; rd_d = id_rd; alu_d = id_alu_ctrl;
      use_imm_d = id_use_imm; use_pc_d = id_use_pc;
      rw_d = id_reg_write; mr_d = id_mem_read; mw_d = id_mem_write;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0; pc_q <= RESET_PC; rs1_q <= '0; rs2_q <= '0; d1_q <= '0; d2_q <= '0;
      imm_q <= '0; rd_q <= '0; alu_q <= ALU_ADD; use_imm_q <= 1'b0; use_pc_q <= 1'b0;
      rw_q <= 1'b0; mr_q <= 1'b0; mw_q <= 1'b0;
    end else begin
      valid_q <= valid_d; pc_q <= pc_d; rs1_q <= rs1_d; rs2_q <= rs2_d; d1_q <= d1_d;
      d2_q <= d2_d; imm_q <= imm_d; rd_q <= rd_d; alu_q <= alu_d; use_imm_q <= use_imm_d;
      use_pc_q <= use_pc_d; rw_q <= rw_d; mr_q <= mr_d; mw_q <= mw_d;
    end
  end
  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
    .idx_i(rs1_q), .stored_i(d1_q), .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
    .mem_result_i(mem_result), .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write),
    .wb_result_i(wb_result), .val_o(fwd1)
  );
  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
    .idx_i(rs2_q), .stored_i(d2_q), .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
    .mem_result_i(mem_result), .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write),
    .wb_result_i(wb_result), .val_o(fwd2)
  );
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_A          = use_pc_q ? pc_q : fwd1;
  assign ex_B          = use_imm_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign ex_alu_ctrl   = alu_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic against a behavioural EX-slot model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
`ifdef OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1;
  logic id_valid, id_rs1_used, id_rs2_used, id_use_imm, id_use_pc;
  logic id_reg_write, id_mem_read, id_mem_write, mem_stall, flush, mem_reg_write, wb_reg_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [3:0] id_alu_ctrl;
  logic id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_A, ex_B, ex_store_data;
  logic [3:0] ex_alu_ctrl;
  logic [4:0] ex_rd;
  int total = 0, bad = 0;

  typedef struct {
    bit v; bit ui; bit up; bit rw; bit mr; bit mw;
    logic [31:0] pc; logic [31:0] d1; logic [31:0] d2; logic [31:0] imm;
    logic [4:0] r1; logic [4:0] r2; logic [4:0] rd; logic [3:0] alu;
  } slot_t;
  slot_t m;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rd(id_rd),
    .id_alu_ctrl(id_alu_ctrl), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_stall(mem_stall), .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_A(ex_A), .ex_B(ex_B),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_rd = 0; id_alu_ctrl = 4'(ALU_ADD);
    id_use_imm = 0; id_use_pc = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_stall = 0; flush = 0; mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit match(input logic [4:0] idx, input logic [4:0] rd, input bit we);
    return we && idx != 0 && idx == rd;
  endfunction

  function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] d);
    if (FWD && match(idx, mem_rd, mem_reg_write)) return mem_result;
    if (FWD && match(idx, wb_rd, wb_reg_write)) return wb_result;
    return d;
  endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.ui = 0; s.up = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.pc = 32'h0;
    s.d1 = 0; s.d2 = 0; s.imm = 0; s.r1 = 0; s.r2 = 0; s.rd = 0; s.alu = 4'(ALU_ADD);
    return s;
  endfunction

  task automatic test_reset();
    idle();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rs2 = 2; id_rs1_data = 32'h12;
    id_rs2_data = 32'h34; id_rd = 3; id_alu_ctrl = 4'(ALU_SUB); id_use_pc = 1; id_reg_write = 1;
    tick(); tick();
    #2 rst_n = 0; #1;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
    total++;
    if (ex_alu_ctrl !== 4'(ALU_ADD)) begin bad++; $display("FAIL reset_alu got=%0h exp=%0h", ex_alu_ctrl, 4'(ALU_ADD)); end
    total++;
    if (ex_A !== 32'h0 || ex_B !== 32'h0) begin bad++; $display("FAIL reset_ops got=%0h/%0h exp=0/0", ex_A, ex_B); end
    total++;
    if (ex_pc !== 32'h0 || ex_rd !== 5'd0) begin bad++; $display("FAIL reset_pc_rd got=%0h/%0h exp=0/0", ex_pc, ex_rd); end
    total++;
    idle();
    tick();
    #2 rst_n = 1;
    tick();
  endtask

  task automatic test_capture();
    idle();
    id_valid = 1; id_pc = 32'h40; id_rs1 = 1; id_rs2 = 2; id_rs1_used = 1; id_rs2_used = 1;
    id_rs1_data = 5; id_rs2_data = 7; id_rd = 3; id_reg_write = 1;
    tick();
    if (ex_A !== 32'd5 || ex_B !== 32'd7) begin bad++; $display("FAIL capture_ops got=%0h/%0h exp=5/7", ex_A, ex_B); end
    total++;
    if (ex_rd !== 5'd3 || ex_alu_ctrl !== 4'(ALU_ADD) || ex_valid !== 1'b1) begin
      bad++; $display("FAIL capture_ctrl got rd=%0h alu=%0h v=%0h exp rd=3 alu=0 v=1", ex_rd, ex_alu_ctrl, ex_valid);
    end
    total++;
    if (ex_pc !== 32'h40 || ex_reg_write !== 1'b1) begin bad++; $display("FAIL capture_pc got=%0h/%0h exp=40/1", ex_pc, ex_reg_write); end
    total++;
  endtask

  task automatic test_forward();
    idle();
    id_valid = 1; id_rs1 = 4; id_rs1_used = 1; id_rs1_data = 32'h11; id_rd = 9; id_reg_write = 1;
    tick();
    idle();
    mem_rd = 4; mem_reg_write = 1; mem_result = 32'hAA;
    wb_rd = 4; wb_reg_write = 1; wb_result = 32'hBB;
    #1;
    if (ex_A !== (FWD ? 32'hAA : 32'h11)) begin bad++; $display("FAIL fwd_mem_prio got=%0h exp=%0h", ex_A, FWD ? 32'hAA : 32'h11); end
    total++;
    mem_reg_write = 0; #1;
    if (ex_A !== (FWD ? 32'hBB : 32'h11)) begin bad++; $display("FAIL fwd_wb got=%0h exp=%0h", ex_A, FWD ? 32'hBB : 32'h11); end
    total++;
    idle();
    id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs1_data = 32'h33;
    tick();
    id_valid = 0; mem_rd = 0; mem_reg_write = 1; mem_result = 32'hCC;
    wb_rd = 0; wb_reg_write = 1; wb_result = 32'hDD;
    #1;
    if (ex_A !== 32'h33) begin bad++; $display("FAIL fwd_x0 got=%0h exp=33", ex_A); end
    total++;
    idle();
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; id_rs1 = 1; id_rs1_used = 1; id_rd = 6; id_mem_read = 1; id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_rs1 = 6; id_rs1_used = 1; id_rs1_data = 32'h99; id_rd = 7; id_reg_write = 1;
    #1;
    if (id_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h exp=1", id_stall); end
    total++;
    tick();
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
    total++;
    mem_rd = 6; mem_reg_write = 1; mem_result = 32'h66;
    #1;
`ifdef OPERAND_FORWARD_EN
    if (id_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%0h exp=0", id_stall); end
    total++;
    tick();
`else
    if (id_stall !== 1'b1) begin bad++; $display("FAIL raw_mem_stall got=%0h exp=1", id_stall); end
    total++;
    tick();
    mem_reg_write = 0; wb_rd = 6; wb_reg_write = 1; wb_result = 32'h66; #1;
    if (id_stall !== 1'b1 || ex_valid !== 1'b0) begin bad++; $display("FAIL raw_wb_stall got=%0h/%0h exp=1/0", id_stall, ex_valid); end
    total++;
    tick();
    wb_reg_write = 0; id_rs1_data = 32'h66; #1;
    if (id_stall !== 1'b0) begin bad++; $display("FAIL raw_release got=%0h exp=0", id_stall); end
    total++;
    tick();
`endif
    if (ex_valid !== 1'b1 || ex_A !== 32'h66) begin bad++; $display("FAIL lu_consumer got v=%0h A=%0h exp v=1 A=66", ex_valid, ex_A); end
    total++;
    idle();
  endtask

  task automatic test_hold();
    idle();
    id_valid = 1; id_rs2 = 5; id_rs2_used = 1; id_rs2_data = 32'h10; id_rd = 8; id_reg_write = 1;
    tick();
    idle();
    mem_stall = 1; wb_rd = 5; wb_reg_write = 1; wb_result = 32'h55;
    #1;
    if (id_stall !== 1'b1) begin bad++; $display("FAIL hold_stall got=%0h exp=1", id_stall); end
    total++;
    tick();
    wb_reg_write = 0;
    #1;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin bad++; $display("FAIL hold_keep got v=%0h rd=%0h exp v=1 rd=8", ex_valid, ex_rd); end
    total++;
    tick(); tick();
    mem_stall = 0; #1;
    if (ex_B !== 32'h55 || ex_store_data !== 32'h55) begin bad++; $display("FAIL hold_wb_capture got=%0h/%0h exp=55/55", ex_B, ex_store_data); end
    total++;
    if (ex_rd !== 5'd8 || ex_valid !== 1'b1) begin bad++; $display("FAIL hold_release got rd=%0h v=%0h exp rd=8 v=1", ex_rd, ex_valid); end
    total++;
    idle();
  endtask

  task automatic test_flush();
    idle();
    id_valid = 1; id_rs1 = 1; id_rd = 6; id_pc = 32'h80; id_mem_read = 1; id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_pc = 32'h84; id_rs1 = 6; id_rs1_used = 1; id_rd = 7; id_reg_write = 1; flush = 1;
    #1;
    if (id_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0h exp=0", id_stall); end
    total++;
    tick();
    if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0) begin
      bad++; $display("FAIL flush_bubble got v=%0h pc=%0h rd=%0h exp 0/0/0", ex_valid, ex_pc, ex_rd);
    end
    total++;
    idle();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, es;
    bit hz, hs, raw, est;
    idle();
    #2 rst_n = 0; #2 rst_n = 1;
    m = empty_slot();
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(9) < 8); id_pc = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3)); id_rd = 5'($urandom_range(3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_alu_ctrl = 4'($urandom_range(11));
      id_use_imm = 1'($urandom); id_use_pc = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
      flush = ($urandom_range(9) == 0); mem_stall = !flush && ($urandom_range(6) == 0);
      mem_rd = 5'($urandom_range(3)); mem_reg_write = 1'($urandom); mem_result = $urandom;
      wb_rd = 5'($urandom_range(3)); wb_reg_write = 1'($urandom); wb_result = $urandom;
      #1;
      ea = m.up ? m.pc : fwd_val(m.r1, m.d1);
      eb = m.ui ? m.imm : fwd_val(m.r2, m.d2);
      es = fwd_val(m.r2, m.d2);
      hz = id_valid && ((id_rs1_used && match(id_rs1, m.rd, m.v && m.rw)) ||
                        (id_rs2_used && match(id_rs2, m.rd, m.v && m.rw)));
      raw = hz || (id_valid &&
        ((id_rs1_used && (match(id_rs1, mem_rd, mem_reg_write) || match(id_rs1, wb_rd, wb_reg_write))) ||
         (id_rs2_used && (match(id_rs2, mem_rd, mem_reg_write) || match(id_rs2, wb_rd, wb_reg_write)))));
      hs = FWD ? (hz && m.mr) : raw;
      est = !flush && (mem_stall || hs);
      if (id_stall !== est) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0h exp=%0h", i, id_stall, est); end
      total++;
      if ({ex_A, ex_B, ex_store_data} !== {ea, eb, es}) begin
        bad++; $display("FAIL rnd_ops cyc=%0d got=%h/%h/%h exp=%h/%h/%h", i, ex_A, ex_B, ex_store_data, ea, eb, es);
      end
      total++;
      if ({ex_valid, ex_pc, ex_alu_ctrl, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write} !==
          {m.v, m.pc, m.alu, m.rd, m.rw, m.mr, m.mw}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got v=%0h pc=%h alu=%0h rd=%0h exp v=%0h pc=%h alu=%0h rd=%0h",
                        i, ex_valid, ex_pc, ex_alu_ctrl, ex_rd, m.v, m.pc, m.alu, m.rd);
      end
      total++;
      if (flush || (!mem_stall && (hs || !id_valid))) m = empty_slot();
      else if (mem_stall) begin
        if (match(m.r1, wb_rd, wb_reg_write)) m.d1 = wb_result;
        if (match(m.r2, wb_rd, wb_reg_write)) m.d2 = wb_result;
      end else begin
        m.v = 1; m.pc = id_pc; m.r1 = id_rs1; m.r2 = id_rs2; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
        m.imm = id_imm; m.rd = id_rd; m.alu = id_alu_ctrl; m.ui = id_use_imm; m.up = id_use_pc;
        m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    #2 rst_n = 0;
    #10 rst_n = 1;
    tick();
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_hold();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
